// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency single-port memory between instruction
//            fetch and data access. Data has priority, with a bounded streak.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_kill,
    output logic        o_if_gnt,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] c_max_streak = SW'(MAX_STREAK);
    localparam logic [CW-1:0] c_lat_load   = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_owner_d;
    logic            r_store;
    logic            r_killed;
    logic [SW-1:0]   r_streak;
    logic [CW-1:0]   r_cnt;
    logic            r_if_gnt;
    logic            r_if_valid;
    logic [31:0]     r_if_rdata;
    logic            r_d_gnt;
    logic            r_d_valid;
    logic [31:0]     r_d_rdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;

    logic            w_any_req;
    logic            w_pick_data;
    logic            w_kill;
    logic            w_drop_fetch;
    logic [SW-1:0]   w_streak_inc;

    assign w_any_req    = i_d_req | i_if_req;
    // Fetch wins a tie only once data has used up its streak allowance.
    assign w_pick_data  = i_d_req && (!i_if_req || (r_streak != c_max_streak));
    assign w_kill       = i_if_kill && !r_owner_d && (r_state != S_IDLE);
    assign w_drop_fetch = r_killed | w_kill;
    assign w_streak_inc = (r_streak == c_max_streak) ? r_streak : r_streak + SW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_store     <= 1'b0;
            r_killed    <= 1'b0;
            r_streak    <= '0;
            r_cnt       <= '0;
            r_if_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_gnt     <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_gnt   <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            if (w_kill) begin
                r_killed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= S_ISSUE;
                        r_mem_en <= 1'b1;
                        if (w_pick_data) begin
                            r_owner_d   <= 1'b1;
                            r_store     <= i_d_we;
                            r_d_gnt     <= 1'b1;
                            r_mem_we    <= i_d_we;
                            r_mem_addr  <= i_d_addr;
                            r_mem_wdata <= i_d_wdata;
                            r_streak    <= i_if_req ? w_streak_inc : '0;
                        end else begin
                            r_owner_d   <= 1'b0;
                            r_store     <= 1'b0;
                            r_if_gnt    <= 1'b1;
                            r_mem_addr  <= i_if_addr;
                            r_streak    <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= c_lat_load;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                        if (r_owner_d) begin
                            r_d_valid <= 1'b1;
                            if (!r_store) begin
                                r_d_rdata <= i_mem_rdata;
                            end
                        end else if (!w_drop_fetch) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    r_killed <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_if_gnt    = r_if_gnt;
    assign o_if_valid  = r_if_valid;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_gnt     = r_d_gnt;
    assign o_d_valid   = r_d_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scenario bench for mem_port_arbiter with a fixed-latency memory.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_mem_en, o_mem_we;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] if_exp[$];
    logic [31:0] d_exp[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] mdl_if_rdata = '0;
    logic [31:0] mdl_d_rdata = '0;
    logic [31:0] exp_v;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
        .o_if_gnt(o_if_gnt), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(o_d_gnt), .o_d_valid(o_d_valid), .o_d_rdata(o_d_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // Memory model: read data is only driven in the single cycle it is due.
    logic [31:0] bus_mem[logic [31:0]];
    int          rd_cnt = 0;
    logic [31:0] rd_word = '0;
    logic [31:0] junk = 32'hBAD0_0000;
    always @(negedge clk) begin
        junk = junk + 32'd1;
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            mem_rdata = (rd_cnt == 0) ? rd_word : junk;
        end else begin
            mem_rdata = junk;
        end
        if (o_mem_en) begin
            if (o_mem_we) begin
                bus_mem[o_mem_addr] = o_mem_wdata;
            end else begin
                rd_word = bus_mem.exists(o_mem_addr) ? bus_mem[o_mem_addr] : mem_init(o_mem_addr);
                rd_cnt  = MEM_LAT;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((which == 0 && o_if_gnt) || (which == 1 && o_d_gnt) ||
                (which == 2 && o_if_valid) || (which == 3 && o_d_valid)) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_mem_en, o_mem_we} !== 6'b0)
            $display("FAIL reset_pulses: got %b required 000000",
                     {o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_mem_en, o_mem_we});
        else n_pass++;
        n_checks++;
        if ({o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata} !== 128'd0)
            $display("FAIL reset_data: got if_rdata=%h d_rdata=%h addr=%h wdata=%h required all 0",
                     o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata);
        else n_pass++;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({o_if_gnt, o_d_gnt, o_mem_en} !== 3'b0)
            $display("FAIL idle_no_req: got gnt/mem_en=%b required 000", {o_if_gnt, o_d_gnt, o_mem_en});
        else n_pass++;
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1;
        if_addr = 32'h10;
        if_exp.push_back(ref_rd(32'h10));
        mdl_if_rdata = ref_rd(32'h10);
        tick();
        n_checks++;
        if (!(o_if_gnt === 1'b1 && o_mem_en === 1'b1 && o_mem_we === 1'b0 &&
              o_mem_addr === 32'h10 && o_d_gnt === 1'b0))
            $display("FAIL fetch_issue: got if_gnt=%b mem_en=%b we=%b addr=%h d_gnt=%b required 1 1 0 00000010 0",
                     o_if_gnt, o_mem_en, o_mem_we, o_mem_addr, o_d_gnt);
        else n_pass++;
        if_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_if_valid !== 1'b0) $display("FAIL fetch_early_valid: got %b at cycle 3 required 0", o_if_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (o_if_valid !== 1'b1 || if_exp.size() == 0)
            $display("FAIL fetch_valid: got if_valid=%b at cycle 4 required 1", o_if_valid);
        else begin
            exp_v = if_exp.pop_front();
            if (o_if_rdata !== exp_v) $display("FAIL fetch_rdata: got %h required %h", o_if_rdata, exp_v);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (o_if_valid !== 1'b0 || o_if_rdata !== 32'hDEAD_BEEF)
            $display("FAIL fetch_hold: got valid=%b rdata=%h required 0 deadbeef", o_if_valid, o_if_rdata);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int dg, dv, ig, iv;
        dg = -1; dv = -1; ig = -1; iv = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h08;
        d_exp.push_back(ref_rd(32'h40));
        mdl_d_rdata = ref_rd(32'h40);
        if_exp.push_back(ref_rd(32'h08));
        mdl_if_rdata = ref_rd(32'h08);
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (o_d_gnt && dg < 0) begin dg = c; d_req = 1'b0; end
            if (o_if_gnt && ig < 0) begin ig = c; if_req = 1'b0; end
            if (o_d_valid && dv < 0) begin
                dv = c;
                n_checks++;
                if (d_exp.size() == 0) $display("FAIL sim_d_unexpected: got d_valid required none");
                else begin
                    exp_v = d_exp.pop_front();
                    if (o_d_rdata !== exp_v) $display("FAIL sim_d_rdata: got %h required %h", o_d_rdata, exp_v);
                    else n_pass++;
                end
            end
            if (o_if_valid && iv < 0) begin
                iv = c;
                n_checks++;
                if (if_exp.size() == 0) $display("FAIL sim_if_unexpected: got if_valid required none");
                else begin
                    exp_v = if_exp.pop_front();
                    if (o_if_rdata !== exp_v) $display("FAIL sim_if_rdata: got %h required %h", o_if_rdata, exp_v);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (dg != 1 || dv != 4 || ig != 6 || iv != 9)
            $display("FAIL sim_timing: got d_gnt=%0d d_valid=%0d if_gnt=%0d if_valid=%0d required 1 4 6 9",
                     dg, dv, ig, iv);
        else n_pass++;
    endtask

    task automatic test_starvation();
        logic [9:0] seq;
        int         n;
        logic       overlap;
        seq = '0; n = 0; overlap = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h200;
        for (int c = 0; c < 80 && n < 10; c++) begin
            tick();
            if (o_d_gnt && o_if_gnt) overlap = 1'b1;
            if (o_d_gnt) begin
                seq = {seq[8:0], 1'b1}; n++;
                d_exp.push_back(ref_rd(32'h100));
                mdl_d_rdata = ref_rd(32'h100);
            end
            if (o_if_gnt) begin
                seq = {seq[8:0], 1'b0}; n++;
                if_exp.push_back(ref_rd(32'h200));
                mdl_if_rdata = ref_rd(32'h200);
            end
            if (o_d_valid) begin
                n_checks++;
                exp_v = (d_exp.size() != 0) ? d_exp[0] : ~o_d_rdata;
                if (d_exp.size() != 0) void'(d_exp.pop_front());
                if (o_d_rdata !== exp_v) $display("FAIL starve_d_rdata: got %h required %h", o_d_rdata, exp_v);
                else n_pass++;
            end
            if (o_if_valid) begin
                n_checks++;
                exp_v = (if_exp.size() != 0) ? if_exp[0] : ~o_if_rdata;
                if (if_exp.size() != 0) void'(if_exp.pop_front());
                if (o_if_rdata !== exp_v) $display("FAIL starve_if_rdata: got %h required %h", o_if_rdata, exp_v);
                else n_pass++;
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        wait_for(2, 10, n);
        n_checks++;
        if (n < 0 || if_exp.size() == 0) $display("FAIL starve_last_fetch: got no if_valid required one");
        else begin
            exp_v = if_exp.pop_front();
            if (o_if_rdata !== exp_v) $display("FAIL starve_last_rdata: got %h required %h", o_if_rdata, exp_v);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (seq !== 10'b1111011110 || overlap)
            $display("FAIL starve_seq: got %b overlap=%b required 1111011110 overlap=0", seq, overlap);
        else n_pass++;
    endtask

    task automatic test_store_load();
        int          w;
        logic [31:0] prev;
        prev = mdl_d_rdata;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
        ref_mem[32'h20] = 32'h55;
        d_exp.push_back(mdl_d_rdata);
        wait_for(1, 20, w);
        n_checks++;
        if (w < 0 || o_mem_en !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 32'h20 || o_mem_wdata !== 32'h55)
            $display("FAIL store_issue: got gnt_wait=%0d en=%b we=%b addr=%h wdata=%h required en=1 we=1 addr=20 wdata=55",
                     w, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
        else n_pass++;
        d_req = 1'b0; d_we = 1'b0;
        wait_for(3, 20, w);
        n_checks++;
        if (w < 0 || d_exp.size() == 0) $display("FAIL store_valid: got no d_valid required one");
        else begin
            exp_v = d_exp.pop_front();
            if (o_d_rdata !== exp_v || o_d_rdata !== prev)
                $display("FAIL store_rdata_kept: got %h required %h", o_d_rdata, prev);
            else n_pass++;
        end
        tick();
        d_req = 1'b1; d_addr = 32'h20;
        d_exp.push_back(ref_rd(32'h20));
        mdl_d_rdata = ref_rd(32'h20);
        wait_for(1, 20, w);
        n_checks++;
        if (w < 0 || o_mem_we !== 1'b0) $display("FAIL load_issue: got gnt_wait=%0d we=%b required gnt we=0", w, o_mem_we);
        else n_pass++;
        d_req = 1'b0;
        wait_for(3, 20, w);
        n_checks++;
        if (w < 0 || d_exp.size() == 0) $display("FAIL load_valid: got no d_valid required one");
        else begin
            exp_v = d_exp.pop_front();
            if (o_d_rdata !== exp_v || o_d_rdata !== 32'h55)
                $display("FAIL load_rdata: got %h required 00000055", o_d_rdata);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_kill();
        int          w;
        logic        seen;
        logic [31:0] prev;
        prev = mdl_if_rdata;
        if_req = 1'b1; if_addr = 32'h30;
        wait_for(0, 20, w);
        n_checks++;
        if (w < 0) $display("FAIL kill_gnt: got no if_gnt required one");
        else n_pass++;
        if_req = 1'b0;
        tick();
        if_kill = 1'b1;
        tick();
        if_kill = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < MEM_LAT + 3; i++) begin
            if (o_if_valid) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0 || o_if_rdata !== prev)
            $display("FAIL kill_suppress: got valid_seen=%b rdata=%h required 0 %h", seen, o_if_rdata, prev);
        else n_pass++;
        if_req = 1'b1; if_addr = 32'h34;
        if_exp.push_back(ref_rd(32'h34));
        mdl_if_rdata = ref_rd(32'h34);
        wait_for(0, 20, w);
        if_req = 1'b0;
        wait_for(2, 20, w);
        n_checks++;
        if (w < 0 || if_exp.size() == 0) $display("FAIL kill_next_valid: got no if_valid required one");
        else begin
            exp_v = if_exp.pop_front();
            if (o_if_rdata !== exp_v) $display("FAIL kill_next_rdata: got %h required %h", o_if_rdata, exp_v);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int   w;
        logic seen;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        wait_for(1, 20, w);
        d_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_mem_en, o_mem_we} !== 6'b0 ||
            {o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata} !== 128'd0)
            $display("FAIL midreset_outputs: got pulses=%b d_rdata=%h if_rdata=%h addr=%h required all 0",
                     {o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_mem_en, o_mem_we},
                     o_d_rdata, o_if_rdata, o_mem_addr);
        else n_pass++;
        mdl_d_rdata = '0;
        mdl_if_rdata = '0;
        rst = 1'b0;
        d_req = 1'b1; d_addr = 32'h64;
        d_exp.push_back(ref_rd(32'h64));
        mdl_d_rdata = ref_rd(32'h64);
        tick();
        n_checks++;
        if (o_d_gnt !== 1'b1) $display("FAIL midreset_regrant: got d_gnt=%b required 1", o_d_gnt);
        else n_pass++;
        d_req = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            tick();
            if (o_d_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midreset_stale: got early d_valid=1 required 0");
        else n_pass++;
        tick();
        n_checks++;
        if (o_d_valid !== 1'b1 || d_exp.size() == 0) $display("FAIL midreset_valid: got d_valid=%b required 1", o_d_valid);
        else begin
            exp_v = d_exp.pop_front();
            if (o_d_rdata !== exp_v) $display("FAIL midreset_rdata: got %h required %h", o_d_rdata, exp_v);
            else n_pass++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store_load();
        test_kill();
        test_reset_mid();
        n_checks++;
        if (if_exp.size() != 0 || d_exp.size() != 0)
            $display("FAIL scoreboard_drain: got if=%0d d=%0d pending required 0 0", if_exp.size(), d_exp.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port main memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Accepts one-at-a-time requests from both sides and sequences each through a fixed-latency memory access. Returns read data with a one-cycle valid pulse. Data accesses have priority, with a bounded-streak rule so instruction fetch cannot starve.

## Interface
- MEM_LAT, 2, cycles from `mem_en` high to `mem_rdata` valid (≥1)
- MAX_STREAK, 4, max consecutive data grants while `if_req` is pending (≥1)
- CLOCK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high
- if_req  in  1  fetch wants one read transaction (level)
- if_addr  in  32  fetch address, stable while `if_req` high
- if_kill  in  1  cancel outstanding fetch result (branch/jump taken)
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data side wants one transaction (level)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  32  load data
- mem_en  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable, qualified by `mem_en`
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after `mem_en`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only here.
  - If any request is high, the arbiter registers the winner as `owner` and latches addr/we/wdata, then moves to ISSUE.
  - If no request is high, it stays in IDLE.
- Winner selection:
  - Only `d_req` high → data wins.
  - Only `if_req` high → fetch wins.
  - Both high → data wins unless `streak == MAX_STREAK`, in which case fetch wins.
- `streak` counter (width clog2(MAX_STREAK+1)):
  - +1 on a data grant while `if_req` is high.
  - Cleared on any fetch grant, or on a data grant with `if_req` low.
  - Saturates at MAX_STREAK.
- ISSUE (1 cycle):
  - `mem_en` = 1; `mem_we`, `mem_addr` and `mem_wdata` come from the latched values.
  - The owner's `*_gnt` = 1.
  - The latency counter loads MEM_LAT−1, then the state moves to WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 0, `mem_rdata` is captured into the owner's rdata register and the state moves to RESP.
  - If owner = data and the access is a store, `d_rdata` is not updated.
- RESP (1 cycle): the owner's `*_valid` = 1, then the state returns to IDLE.
- `if_kill`, sampled in ISSUE, WAIT or RESP while owner = fetch:
  - Sets a `killed` flag.
  - That transaction completes on the memory side but `if_valid` stays 0 and `if_rdata` is not updated.
  - `killed` clears on return to IDLE.
  - `if_kill` has no effect in IDLE or while owner = data.
- Requester rule: after seeing `*_gnt`, a requester holds `req` high only if it wants another transaction. Each grant consumes exactly one request.
- Reset:
  - State → IDLE; `streak`, `killed`, `owner` and the counter → 0.
  - All outputs → 0, including both rdata registers.
  - An in-flight access is abandoned; its late `mem_rdata` is ignored.

## Timing
- A request sampled in IDLE at cycle t produces:
  - `*_gnt` and `mem_en` at t+1.
  - `mem_rdata` captured at t+1+MEM_LAT.
  - `*_valid` at t+2+MEM_LAT.
- The next IDLE sample is at t+3+MEM_LAT, so throughput is one transaction per MEM_LAT+3 cycles.
- `gnt`, `valid` and `mem_en` are registered single-cycle pulses and never overlap between the two owners.
- `rdata` outputs hold their value until the next update of the same side.

## Test plan
- Single fetch, MEM_LAT=2:
  - Stimulus: `if_req`=1, `if_addr`=0x10 at cycle 0; memory returns 0xDEADBEEF.
  - Response: `if_gnt`, `mem_en`, `mem_addr`=0x10 at cycle 1; `if_valid` with `if_rdata`=0xDEADBEEF at cycle 4.
- Simultaneous requests:
  - Stimulus: `d_req` (load 0x40) and `if_req` (0x08) both high at cycle 0.
  - Response: `d_gnt` at cycle 1, `d_valid` at cycle 4, `if_gnt` at cycle 6.
- Starvation bound, MAX_STREAK=4:
  - Stimulus: `d_req` and `if_req` held high continuously.
  - Response: the grant sequence is D,D,D,D,F,D,D,D,D,F…
- Store then load:
  - Stimulus: store 0x55 to 0x20, then load from 0x20.
  - Response:
    - During the store, `mem_we`=1 and `mem_wdata`=0x55.
    - `d_valid` pulses and `d_rdata` is unchanged.
    - The load then returns 0x55.
- Kill:
  - Stimulus: `if_kill` pulsed in WAIT of a fetch.
  - Response: no `if_valid` and `if_rdata` unchanged; the next fetch completes normally.
- Reset mid-operation:
  - Stimulus: RESET asserted in WAIT of a data load.
  - Response:
    - All outputs are 0 on the next cycle and the state is IDLE.
    - The stale `mem_rdata` produces no `d_valid`.
    - A fresh request is granted 1 cycle after RESET deasserts.
